// File: rtl/ga23_pkg.sv
// ga23_pkg: shared widths and fetch FSM state type for the GA23 tile-row fetch path.
package ga23_pkg;
   localparam int GA23_ROW_W      = 32;
   localparam int GA23_SDR_ADDR_W = 22;
   typedef enum logic {IDLE, WAIT} fetch_state_t;
endpackage

// File: rtl/ga23_rr_pick.sv
// ga23_rr_pick: combinational round-robin picker, first set request after last (mod N).
module ga23_rr_pick
   import ga23_pkg::*;
#(
   parameter int N     = 3,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last,
   output logic [IDX_W-1:0] grant,
   output logic             valid
);
   logic [IDX_W-1:0] idx;
   // Scan from farthest to nearest so the nearest set index after last wins.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int k = N; k >= 1; k--) begin
         idx = IDX_W'((int'(last) + k) % N);
         if (req[idx]) begin
            grant = idx;
            valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/ga23_tile_fetch_arbiter.sv
// ga23_tile_fetch_arbiter: round-robin arbiter of per-layer tile-row fetches onto one SDRAM channel.
module ga23_tile_fetch_arbiter
   import ga23_pkg::*;
#(
   parameter int NUM_PORTS = 3,
   parameter int ADDR_W    = GA23_SDR_ADDR_W,
   parameter int DATA_W    = GA23_ROW_W
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_PORTS-1:0]                sdr_req,
   input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    sdr_addr,
   output logic [NUM_PORTS-1:0][DATA_W-1:0]    sdr_data,
   output logic [NUM_PORTS-1:0]                sdr_rdy,
   output logic                                mem_req,
   output logic [ADDR_W-1:0]                   mem_addr,
   input  logic                                mem_ack,
   input  logic [DATA_W-1:0]                   mem_data,
   output logic                                busy
);
   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   fetch_state_t                     state, state_n;
   logic [NUM_PORTS-1:0]             pend, clr;
   logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_q;
   logic [IDX_W-1:0]                 cur, last_grant, grant;
   logic                             stale, pick_v, issue;
   ga23_rr_pick #(.N(NUM_PORTS), .IDX_W(IDX_W)) u_pick (
      .req   (pend),
      .last  (last_grant),
      .grant (grant),
      .valid (pick_v)
   );
   assign issue = (state == IDLE) && pick_v;
   assign clr   = issue ? NUM_PORTS'(1) << grant : '0;
   assign busy  = |pend || (state == WAIT);
   always_comb begin
      state_n = (state == IDLE) ? (pick_v ? WAIT : IDLE) : (mem_ack ? IDLE : WAIT);
   end
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= state_n;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         pend       <= '0;
         addr_q     <= '0;
         stale      <= 1'b0;
         cur        <= '0;
         last_grant <= IDX_W'(NUM_PORTS - 1);
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         sdr_data   <= '0;
         sdr_rdy    <= '0;
      end else begin
         // A request landing on the granted port in the issue cycle keeps it pending.
         pend    <= (pend & ~clr) | sdr_req;
         sdr_rdy <= '0;
         for (int i = 0; i < NUM_PORTS; i++)
            if (sdr_req[i]) addr_q[i] <= sdr_addr[i];
         if (issue) begin
            mem_req  <= 1'b1;
            mem_addr <= addr_q[grant];
            cur      <= grant;
         end
         if (state == WAIT) begin
            if (mem_ack) begin
               mem_req    <= 1'b0;
               last_grant <= cur;
               stale      <= 1'b0;
               if (!stale) begin
                  sdr_data[cur] <= mem_data;
                  sdr_rdy[cur]  <= 1'b1;
               end
            end else if (sdr_req[cur]) begin
               stale <= 1'b1;
            end
         end
      end
   end
endmodule
